dma_pingpong_ctrl: RTL and testbench
====================================

Name: dma_pingpong_ctrl

Overview:
Per-port controller that fronts one pair of DMA SRAM banks (512x32 single-port macros) and turns them into a ping-pong frame buffer. An upstream valid/ready stream fills one bank while the previously filled bank drains to a downstream valid/ready stream. It drives each bank's CEB/WEB/A/D and consumes Q. The DMA engine instantiates one of these per port, DMA_PORTS instances in total.

Parameters:
DATA_WIDTH, 32, word width; matches the SRAM D/Q width.
ADDR_WIDTH, 9, bank address width.
DEPTH, 512, words per bank; must equal 2**ADDR_WIDTH.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
frame_len  in  ADDR_WIDTH+1  words per frame; sampled on the first write of each frame; 0 or >DEPTH means DEPTH.
in_valid  in  1  input word valid.
in_ready  out  1  input word accepted when in_valid&&in_ready.
in_data  in  DATA_WIDTH  input word.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_WIDTH  output word.
out_last  out  1  marks the final word of a frame.
bank_ceb  out  2  per-bank chip enable, active-low.
bank_web  out  2  per-bank write enable, active-low; 1 = read.
bank_a  out  2*ADDR_WIDTH  per-bank address; bank b uses [b*ADDR_WIDTH +: ADDR_WIDTH].
bank_d  out  DATA_WIDTH  write data, shared by both banks.
bank_q  in  2*DATA_WIDTH  per-bank read data, valid the cycle after a read.

Behaviour:
- Reset (rst=1 at an edge): both banks EMPTY; wr_sel=rd_sel=0; wr_cnt=rd_cnt=0; output FIFO emptied; in-flight read cleared.
- Reset outputs while rst is high: bank_ceb=2'b11, bank_web=2'b11, bank_a=0, bank_d=0, in_ready=0, out_valid=0, out_last=0.
- Reset mid-frame discards all partial or full bank contents. in_ready=1 in the first cycle after rst deasserts.
- Bank state per bank: EMPTY -> FILLING (first write) -> FULL (last write) -> DRAINING (first read) -> EMPTY (cycle after the last read is issued).
- A frame of length 1 goes EMPTY->FULL directly on the write, and FULL->EMPTY on the single read.
- Write side:
  - in_ready = !rst && state[wr_sel] is EMPTY or FILLING.
  - On handshake: ceb[wr_sel]=0, web[wr_sel]=0, a=wr_cnt, bank_d=in_data, all in the same cycle (combinational).
  - The first word latches len[wr_sel].
  - When wr_cnt==len-1: the bank goes FULL, wr_cnt returns to 0, and wr_sel toggles.
- Read side:
  - A read issues when state[rd_sel] is FULL or DRAINING and fifo_count+inflight < 3.
  - On issue: ceb[rd_sel]=0, web[rd_sel]=1, a=rd_cnt.
  - Next cycle, bank_q[rd bank] is pushed into the 3-entry output FIFO together with a last flag (rd_cnt==len-1 at issue).
  - After the last read: the bank goes EMPTY, rd_cnt returns to 0, and rd_sel toggles.
- No bank is ever written and read in the same cycle; this follows from the state rules. Both bank_ceb bits can be low together, one bank written and the other read.
- Latency:
  - First word of a frame accepted in cycle t, len=L, no stalls: the last write happens in cycle t+L-1 and the bank is FULL in t+L.
  - The read issues in t+L, Q is valid in t+L+1, and the first out_valid is in t+L+2.
- Throughput: with out_ready held high, one word per cycle on each side at steady state.
- out_ready may deassert at any time; the FIFO absorbs in-flight data.
- out_valid and out_data hold stable while out_ready=0.
- Both banks FULL: in_ready=0 until the drained bank returns to EMPTY.
- Address counters never exceed len-1; no wrap past DEPTH.
- out_data and out_last are driven from FIFO head registers; there is no combinational path from out_ready to bank controls.

Decomposition:
- Package dma_pkg: bank_state_e enum {EMPTY, FILLING, FULL, DRAINING}; localparams DMA_DEPTH=512, DMA_ADDR_W=9, DMA_DATA_W=32; OUT_FIFO_DEPTH=3.
- Sub-module dma_out_fifo: 3-entry {last,data} FIFO with valid/ready output, count output, and push input.

Test Plan:
1. Reset: hold rst 3 cycles with in_valid=1 -> bank_ceb=2'b11, in_ready=0, out_valid=0; in_ready=1 the cycle after release.
2. Single frame: frame_len=4, words 0xA0..0xA3 back-to-back, out_ready=1 -> writes to bank0 at addresses 0..3; out_data 0xA0..0xA3 in consecutive cycles starting 6 cycles after the first accept; out_last only on 0xA3.
3. Streaming ping-pong: 4 frames of len 8 continuous, out_ready=1 -> no in_ready drop after the first frame; banks alternate 0,1,0,1; 32 words out in order, one out_last per 8 words.
4. Backpressure: len=16, out_ready toggling 1/0 every 2 cycles -> no data loss or duplication; out_data stable while stalled; in_ready drops when both banks are FULL.
5. Boundaries: frame_len=1, frame_len=0 (treated as 512), frame_len=600 (treated as 512) -> the last write address is 0/511/511 and out_last count matches.
6. Mid-frame reset: rst asserted after 5 of 10 words -> no out_valid afterward; the next frame of len 3 (0xB0..0xB2) is output cleanly from bank0.

Source files
------------

// File: rtl/dma_pingpong_ctrl_pkg.sv
// Shared types for the DMA ping-pong controller.
// Bank state enum, SRAM geometry and output FIFO depth.
package dma_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

  localparam int DMA_DEPTH      = 512;
  localparam int DMA_ADDR_W     = 9;
  localparam int DMA_DATA_W     = 32;
  localparam int OUT_FIFO_DEPTH = 3;

  // Pointer advance for the 3-entry ring.
  function automatic logic [1:0] fifo_nxt(
    input logic [1:0] p
  );
    return (p == 2'(OUT_FIFO_DEPTH - 1)) ?
      2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/dma_pingpong_ctrl_if.sv
// Stream and SRAM bank signals of one DMA port.
// slave: controller side; master: environment side.
interface dma_pingpong_ctrl_if
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int ADDR_WIDTH = DMA_ADDR_W
) ();

  logic [ADDR_WIDTH:0]       frame_len;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic                      out_last;
  logic [1:0]                bank_ceb;
  logic [1:0]                bank_web;
  logic [2*ADDR_WIDTH-1:0]   bank_a;
  logic [DATA_WIDTH-1:0]     bank_d;
  logic [2*DATA_WIDTH-1:0]   bank_q;

  modport slave (
    input  frame_len, in_valid, in_data,
    input  out_ready, bank_q,
    output in_ready, out_valid, out_data,
    output out_last, bank_ceb, bank_web,
    output bank_a, bank_d
  );

  modport master (
    output frame_len, in_valid, in_data,
    output out_ready, bank_q,
    input  in_ready, out_valid, out_data,
    input  out_last, bank_ceb, bank_web,
    input  bank_a, bank_d
  );

endinterface

// File: rtl/dma_pingpong_ctrl_out_fifo.sv
// 3-entry {last,data} output FIFO.
// push/push_*: write; head_*/pop: read; count: fill level.
module dma_out_fifo
  import dma_pkg::*;
#(
  parameter int DW = DMA_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic          head_valid,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    count
);

  logic [DW:0] mem [OUT_FIFO_DEPTH];
  logic [1:0]  wp;
  logic [1:0]  rp;
  logic [1:0]  cnt;
  logic        do_pop;

  assign head_valid = (cnt != 2'd0);
  assign do_pop     = pop && head_valid;
  assign head_data  = mem[rp][DW-1:0];
  assign head_last  = mem[rp][DW];
  assign count      = cnt;

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= {push_last, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= fifo_nxt(wp);
      if (do_pop)
        rp <= fifo_nxt(rp);
      cnt <= cnt + {1'b0, push}
                 - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dma_pingpong_ctrl.sv
// Ping-pong frame buffer over two 512x32 SRAM banks.
// clk/rst plain; stream + bank pins via bus (slave).
module dma_pingpong_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int ADDR_WIDTH = DMA_ADDR_W,
  parameter int DEPTH      = DMA_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  dma_pingpong_ctrl_if.slave bus
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  bank_state_e   state [2];
  logic [LW-1:0] len   [2];
  logic          wr_sel;
  logic          rd_sel;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic          inflight;
  logic          inf_bank;
  logic          inf_last;

  logic [LW-1:0] eff_len;
  logic [LW-1:0] wr_len;
  logic          wr_last;
  logic          rd_last;
  logic          in_ready;
  logic          wr_fire;
  logic          rd_issue;

  logic [1:0]    fifo_cnt;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data;
  logic          fifo_last;
  logic [DW-1:0] q_sel;

  logic [1:0]      ceb;
  logic [1:0]      web;
  logic [2*AW-1:0] addr;
  logic [DW-1:0]   wdat;

  assign eff_len =
    (bus.frame_len == '0 ||
     bus.frame_len > LW'(DEPTH)) ?
    LW'(DEPTH) : bus.frame_len;

  // Length is only latched on the first word.
  assign wr_len = (state[wr_sel] == EMPTY) ?
    eff_len : len[wr_sel];
  assign wr_last =
    ({1'b0, wr_cnt} == wr_len - LW'(1));
  assign rd_last =
    ({1'b0, rd_cnt} == len[rd_sel] - LW'(1));

  assign in_ready = !rst &&
    (state[wr_sel] == EMPTY ||
     state[wr_sel] == FILLING);
  assign wr_fire = bus.in_valid && in_ready;

  // Count in-flight reads as occupied slots.
  assign rd_issue = !rst &&
    (state[rd_sel] == FULL ||
     state[rd_sel] == DRAINING) &&
    ({1'b0, fifo_cnt} + {2'b0, inflight}
      < 3'(OUT_FIFO_DEPTH));

  always_comb begin
    ceb  = 2'b11;
    web  = 2'b11;
    addr = '0;
    wdat = '0;
    if (wr_fire) begin
      ceb[wr_sel] = 1'b0;
      web[wr_sel] = 1'b0;
      addr[wr_sel*AW +: AW] = wr_cnt;
      wdat = bus.in_data;
    end
    if (rd_issue) begin
      ceb[rd_sel] = 1'b0;
      addr[rd_sel*AW +: AW] = rd_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      len[0]   <= '0;
      len[1]   <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
      inf_bank <= 1'b0;
      inf_last <= 1'b0;
    end else begin
      inflight <= rd_issue;
      inf_bank <= rd_sel;
      inf_last <= rd_last;
      if (wr_fire) begin
        if (state[wr_sel] == EMPTY)
          len[wr_sel] <= eff_len;
        if (wr_last) begin
          state[wr_sel] <= FULL;
          wr_cnt <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          state[wr_sel] <= FILLING;
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
      if (rd_issue) begin
        if (rd_last) begin
          state[rd_sel] <= EMPTY;
          rd_cnt <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          state[rd_sel] <= DRAINING;
          rd_cnt <= rd_cnt + AW'(1);
        end
      end
    end
  end

  assign q_sel = inf_bank ?
    bus.bank_q[2*DW-1:DW] :
    bus.bank_q[DW-1:0];

  dma_out_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (q_sel),
    .push_last (inf_last),
    .pop       (bus.out_valid && bus.out_ready),
    .head_valid(fifo_valid),
    .head_data (fifo_data),
    .head_last (fifo_last),
    .count     (fifo_cnt)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = fifo_valid && !rst;
  assign bus.out_last  = fifo_last && fifo_valid
                         && !rst;
  assign bus.out_data  = fifo_data;
  assign bus.bank_ceb  = ceb;
  assign bus.bank_web  = web;
  assign bus.bank_a    = addr;
  assign bus.bank_d    = wdat;

endmodule

// File: tb/tb_dma_pingpong_ctrl.sv
// Bench for dma_pingpong_ctrl: SRAM model, frame-level
// reference queue, directed and random stimulus.
module tb_dma_pingpong_ctrl;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } ow_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_pingpong_ctrl_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(9)
  ) bus ();

  dma_pingpong_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [2][512];
  logic [63:0] q_r;
  assign bus.bank_q = q_r;

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!bus.bank_ceb[b]) begin
        if (!bus.bank_web[b])
          mem[b][bus.bank_a[b*9 +: 9]]
            <= bus.bank_d;
        else
          q_r[b*32 +: 32]
            <= mem[b][bus.bank_a[b*9 +: 9]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_cmp = 0;
  int  n_bad = 0;
  ow_t exp_q [$];
  int  wr_pos = 0;
  int  cur_len = 1;
  int  wr_bank = 0;
  int  stall_in = 0;
  int  first_acc = -1;
  int  first_out = -1;
  int  last_out_cyc = 0;
  int  n_last = 0;
  int  n_out = 0;
  int  last_wr_addr = 0;
  int  rmode = 0;
  bit  stim_done = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] expv
  );
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic int efflen(input int fl);
    return (fl == 0 || fl > 512) ? 512 : fl;
  endfunction

  // Reference model: frames in order, ping-pong
  // bank parity, word position within frame.
  initial begin : monitor
    bit          prev_stall = 0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    ow_t         e;
    int          a;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ceb", bus.bank_ceb, 2'b11);
        chk("rst_web", bus.bank_web, 2'b11);
        chk("rst_a", bus.bank_a, 0);
        chk("rst_d", bus.bank_d, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        exp_q.delete();
        wr_pos = 0;
        wr_bank = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, prev_d);
          chk("hold_last", bus.out_last, prev_l);
        end
        if (bus.in_valid && !bus.in_ready)
          stall_in++;
        if (bus.in_valid && bus.in_ready) begin
          if (wr_pos == 0)
            cur_len = efflen(int'(bus.frame_len));
          if (first_acc < 0)
            first_acc = cyc;
          a = int'(bus.bank_a[wr_bank*9 +: 9]);
          chk("wr_ceb", bus.bank_ceb[wr_bank], 0);
          chk("wr_web", bus.bank_web[wr_bank], 0);
          chk("wr_addr", a, wr_pos);
          chk("wr_data", bus.bank_d, bus.in_data);
          last_wr_addr = a;
          e.d = bus.in_data;
          e.l = (wr_pos == cur_len - 1);
          exp_q.push_back(e);
          if (wr_pos == cur_len - 1) begin
            wr_pos = 0;
            wr_bank ^= 1;
          end else begin
            wr_pos++;
          end
        end
        if (bus.out_valid && first_out < 0)
          first_out = cyc;
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (bus.out_last) begin
            n_last++;
            last_out_cyc = cyc;
          end
          n_cmp++;
          assert (exp_q.size() > 0) else begin
            n_bad++;
            $error("FAIL out_extra: observed %0h %s",
                   bus.out_data, "expected none");
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.d);
            chk("out_last", bus.out_last, e.l);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d = bus.out_data;
        prev_l = bus.out_last;
      end
    end
  end

  task automatic put(input logic [31:0] d);
    int w = 0;
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && w < 2000) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else w++;
    end
    chk("in_accept_timeout", ok, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(
    input int          fl,
    input int          n,
    input logic [31:0] base,
    input int          gap_max
  );
    bus.frame_len = 10'(fl);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0)
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      put(base + 32'(i));
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || bus.out_valid)
           && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", w < 5000, 1);
    @(posedge clk); #1;
  endtask

  task automatic drive_ready();
    int k = 0;
    while (!stim_done) begin
      @(posedge clk); #1;
      case (rmode)
        1: bus.out_ready = ((k / 2) % 2 == 0);
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      k++;
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin : stim
    int tot;
    int ov;
    int fl;
    int lens [3];
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5555_aaaa;
    bus.frame_len = 10'd4;
    bus.out_ready = 1'b1;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", bus.in_ready, 1);
    @(posedge clk); #1;

    // 2: single frame, latency
    first_acc = -1;
    first_out = -1;
    n_last = 0;
    send_frame(4, 4, 32'hA0, 0);
    wait_drain();
    chk("lat_first_out", first_out - first_acc, 6);
    chk("lat_last_out", last_out_cyc - first_out, 3);
    chk("t2_last_cnt", n_last, 1);

    // 3: streaming ping-pong
    stall_in = 0;
    n_last = 0;
    n_out = 0;
    rmode = 0;
    stim_done = 0;
    fork
      begin
        for (int f = 0; f < 4; f++)
          send_frame(8, 8, 32'h100 + 32'(f*8), 0);
        wait_drain();
        stim_done = 1;
      end
      drive_ready();
    join
    chk("t3_no_in_stall", stall_in, 0);
    chk("t3_words", n_out, 32);
    chk("t3_lasts", n_last, 4);

    // 4: backpressure
    stall_in = 0;
    n_last = 0;
    n_out = 0;
    rmode = 1;
    stim_done = 0;
    fork
      begin
        for (int f = 0; f < 4; f++)
          send_frame(16, 16,
                     32'h200 + 32'(f*16), 0);
        wait_drain();
        stim_done = 1;
      end
      drive_ready();
    join
    chk("t4_in_stall_seen", stall_in > 0, 1);
    chk("t4_words", n_out, 64);
    chk("t4_lasts", n_last, 4);

    // 5: length boundaries
    lens[0] = 1;
    lens[1] = 0;
    lens[2] = 600;
    for (int i = 0; i < 3; i++) begin
      n_last = 0;
      send_frame(lens[i], efflen(lens[i]),
                 32'h1000 * 32'(i + 1), 0);
      wait_drain();
      chk("t5_last_addr", last_wr_addr,
          efflen(lens[i]) - 1);
      chk("t5_lasts", n_last, 1);
    end

    // random frames, gaps and backpressure
    n_out = 0;
    n_last = 0;
    tot = 0;
    rmode = 2;
    stim_done = 0;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          fl = int'($urandom_range(1, 20));
          tot += fl;
          send_frame(fl, fl, $urandom, 2);
        end
        wait_drain();
        stim_done = 1;
      end
      drive_ready();
    join
    chk("rnd_words", n_out, tot);
    chk("rnd_lasts", n_last, 6);

    // 6: mid-frame reset
    bus.out_ready = 1'b1;
    send_frame(10, 5, 32'h300, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ov = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    chk("t6_no_out", ov, 0);
    @(posedge clk); #1;
    n_out = 0;
    n_last = 0;
    send_frame(3, 3, 32'hB0, 0);
    wait_drain();
    chk("t6_words", n_out, 3);
    chk("t6_lasts", n_last, 1);

    chk("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
